// File: rtl/bcd_seg_display_driver.sv
// Binary-to-7-segment display driver: sequential double-dabble conversion feeding registered digit outputs.
// Optional build macro BLANK_LEADING_ZEROS_EN suppresses zero digits above the most significant nonzero digit.
module bcd_seg_display_driver #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  error,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // ceil(WIDTH*log10(2)) nibbles cover every WIDTH-bit value; never fewer than the displayed digits.
  localparam int NIB   = (WIDTH * 30103 + 99999) / 100000;
  localparam int BCD_N = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_E    = 7'b1111001;
  localparam logic [7*DIGITS-1:0] SEG_BLANK = {7*DIGITS{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     bin_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt_reg;
  logic [7*DIGITS-1:0]  disp_reg;
  logic [7*DIGITS-1:0]  disp_next;
  logic [7*DIGITS-1:0]  seg_reg;
  logic [7*DIGITS-1:0]  seg_next;
  logic [7*DIGITS-1:0]  new_pat;
  logic [7*DIGITS-1:0]  err_pat;
  logic [BCD_N-1:0]     nz;
  logic                 ovf;
  logic                 done_reg;
  logic                 overflow_reg;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1101111;
      default: seg_code = SEG_OFF;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < BCD_N; gi++) begin : g_nibble
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                 : bcd_reg[4*gi +: 4];
      assign nz[gi] = |bcd_reg[4*gi +: 4];
    end

    if (BCD_N > DIGITS) begin : g_ovf
      assign ovf = |nz[BCD_N-1:DIGITS];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end

    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic show;
`ifdef BLANK_LEADING_ZEROS_EN
      assign show = (gi == 0) || (|nz[DIGITS-1:gi]);
`else
      assign show = 1'b1;
`endif
      assign new_pat[7*gi +: 7] = ovf  ? SEG_DASH :
                                  show ? seg_code(bcd_reg[4*gi +: 4]) : SEG_OFF;
      assign err_pat[7*gi +: 7] = (gi == 0) ? SEG_E : SEG_DASH;
    end
  endgenerate

  // disp_reg keeps the last conversion result so it reappears once error drops.
  always_comb begin
    disp_next = (state_reg == UPDATE) ? new_pat : disp_reg;
    seg_next  = error ? err_pat : disp_next;
    if (SEG_ACTIVE_LOW)
      seg_next = ~seg_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      disp_reg     <= '0;
      seg_reg      <= SEG_BLANK;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      disp_reg <= disp_next;
      seg_reg  <= seg_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg   <= in;
            bcd_reg   <= '0;
            cnt_reg   <= CNT_W'(WIDTH - 1);
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
          bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
          if (cnt_reg == '0)
            state_reg <= UPDATE;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        UPDATE: begin
          overflow_reg <= ovf;
          done_reg     <= 1'b1;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg == CONVERT) || (state_reg == UPDATE);
  assign seg      = seg_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_seg_display_driver.sv
// Bench for bcd_seg_display_driver: three instances (3 digits, 2 digits, active-low) share stimulus
// and are compared against a decimal-arithmetic reference model.
module tb_bcd_seg_display_driver;

`ifdef BLANK_LEADING_ZEROS_EN
  localparam bit BLZ = 1'b1;
`else
  localparam bit BLZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_val = '0;
  logic        in_valid = 1'b0;
  logic        error = 1'b0;

  logic        rdy_a, busy_a, done_a, ov_a;
  logic        rdy_b, busy_b, done_b, ov_b;
  logic        rdy_c, busy_c, done_c, ov_c;
  logic [20:0] seg_a;
  logic [13:0] seg_b;
  logic [20:0] seg_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_seg_display_driver #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .in(in_val), .in_valid(in_valid), .in_ready(rdy_a),
    .error(error), .seg(seg_a), .busy(busy_a), .done(done_a), .overflow(ov_a));

  bcd_seg_display_driver #(.WIDTH(8), .DIGITS(2), .SEG_ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .in(in_val), .in_valid(in_valid), .in_ready(rdy_b),
    .error(error), .seg(seg_b), .busy(busy_b), .done(done_b), .overflow(ov_b));

  bcd_seg_display_driver #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1)) u_dut_c (
    .clk(clk), .reset(reset), .in(in_val), .in_valid(in_valid), .in_ready(rdy_c),
    .error(error), .seg(seg_c), .busy(busy_c), .done(done_c), .overflow(ov_c));

  // ---------------- reference model ----------------
  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] code_of(input int n);
    case (n)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  // mode 0: show value v, 1: error pattern, 2: blank
  function automatic logic [20:0] model(input int v, input int d, input bit al, input int mode);
    logic [20:0] r = '0;
    logic [6:0]  p;
    for (int i = 0; i < d; i++) begin
      if (mode == 2)                         p = 7'b0000000;
      else if (mode == 1)                    p = (i == 0) ? 7'b1111001 : 7'b1000000;
      else if (v >= pow10(d))                p = 7'b1000000;
      else if (BLZ && i > 0 && v < pow10(i)) p = 7'b0000000;
      else                                   p = code_of((v / pow10(i)) % 10);
      r[7*i +: 7] = al ? ~p : p;
    end
    return r;
  endfunction

  function automatic int dig_of(input int k);
    return (k == 1) ? 2 : 3;
  endfunction

  function automatic bit al_of(input int k);
    return (k == 2);
  endfunction

  function automatic logic [20:0] seg_of(input int k);
    case (k)
      0:       return seg_a;
      1:       return {7'b0, seg_b};
      default: return seg_c;
    endcase
  endfunction

  function automatic logic ov_of(input int k);
    case (k)
      0:       return ov_a;
      1:       return ov_b;
      default: return ov_c;
    endcase
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers v and returns just after the transfer edge; ok=0 if never accepted.
  task automatic send(input logic [7:0] v, output bit ok);
    in_val   = v;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rdy_a) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Cycles from the transfer edge until done is seen; -1 if it never arrives.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_a === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (seg_of(k) !== model(0, dig_of(k), al_of(k), 2)) begin
        bad++;
        $display("FAIL reset_seg inst%0d got=%b exp=%b", k, seg_of(k), model(0, dig_of(k), al_of(k), 2));
      end
      total++;
      if (ov_of(k) !== 1'b0) begin
        bad++;
        $display("FAIL reset_overflow inst%0d got=%b exp=0", k, ov_of(k));
      end
    end
    total++;
    if ({busy_a, done_a, rdy_a} !== 3'b001) begin
      bad++;
      $display("FAIL reset_ctrl busy/done/ready got=%b exp=001", {busy_a, done_a, rdy_a});
    end
    $display("xfer reset: seg=%b ready=%b", seg_a, rdy_a);
  endtask

  task automatic test_reset_mid_convert();
    bit ok;
    int dones = 0;
    send(8'hE9, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t1_accept got=0 exp=1"); end
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    total++;
    if (seg_a !== 21'b0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL t1_abort seg=%b busy=%b exp seg=0 busy=0", seg_a, busy_a);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (rdy_a !== 1'b1) begin bad++; $display("FAIL t1_ready got=%b exp=1", rdy_a); end
    for (int i = 0; i < 12; i++) begin
      if (done_a === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL t1_no_done got=%0d exp=0", dones); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (seg_of(k) !== model(0, dig_of(k), al_of(k), 2)) begin
        bad++;
        $display("FAIL t1_blank inst%0d got=%b exp=%b", k, seg_of(k), model(0, dig_of(k), al_of(k), 2));
      end
    end
    $display("xfer t1 reset-mid-convert: seg=%b dones=%0d", seg_a, dones);
  endtask

  task automatic test_convert();
    int vals[$] = '{233, 7, 255, 42, 0, 99, 100, 10, 9};
    for (int i = 0; i < 16; i++) vals.push_back(int'($urandom_range(0, 255)));
    foreach (vals[n]) begin
      bit ok;
      int cyc;
      int v = vals[n];
      send(8'(v), ok);
      total++;
      if (!ok || busy_a !== 1'b1 || rdy_a !== 1'b0) begin
        bad++;
        $display("FAIL conv_start v=%0d ok=%0d busy=%b ready=%b exp 1/1/0", v, ok, busy_a, rdy_a);
      end
      wait_done(cyc);
      total++;
      if (cyc != 9) begin bad++; $display("FAIL conv_latency v=%0d got=%0d exp=9", v, cyc); end
      total++;
      if (done_b !== 1'b1 || done_c !== 1'b1) begin
        bad++;
        $display("FAIL conv_done_all v=%0d got=%b%b exp=11", v, done_b, done_c);
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (seg_of(k) !== model(v, dig_of(k), al_of(k), 0)) begin
          bad++;
          $display("FAIL conv_seg v=%0d inst%0d got=%b exp=%b", v, k, seg_of(k), model(v, dig_of(k), al_of(k), 0));
        end
        total++;
        if (ov_of(k) !== (v >= pow10(dig_of(k)))) begin
          bad++;
          $display("FAIL conv_overflow v=%0d inst%0d got=%b exp=%b", v, k, ov_of(k), v >= pow10(dig_of(k)));
        end
      end
      $display("xfer v=%0d cycles=%0d seg3=%b seg2=%b ov3=%b ov2=%b", v, cyc, seg_a, seg_b, ov_a, ov_b);
      tick();
      total++;
      if (done_a !== 1'b0 || seg_a !== model(v, 3, 1'b0, 0)) begin
        bad++;
        $display("FAIL conv_hold v=%0d done=%b seg=%b exp done=0 seg=%b", v, done_a, seg_a, model(v, 3, 1'b0, 0));
      end
    end
  endtask

  task automatic test_error();
    bit ok;
    int cyc;
    send(8'd99, ok);
    error = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (seg_of(k) !== model(0, dig_of(k), al_of(k), 1)) begin
        bad++;
        $display("FAIL err_pattern inst%0d got=%b exp=%b", k, seg_of(k), model(0, dig_of(k), al_of(k), 1));
      end
    end
    wait_done(cyc);
    total++;
    if (cyc != 8) begin bad++; $display("FAIL err_done got=%0d exp=8", cyc); end
    total++;
    if (seg_a !== model(0, 3, 1'b0, 1)) begin
      bad++;
      $display("FAIL err_held_at_done got=%b exp=%b", seg_a, model(0, 3, 1'b0, 1));
    end
    error = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (seg_of(k) !== model(99, dig_of(k), al_of(k), 0)) begin
        bad++;
        $display("FAIL err_release inst%0d got=%b exp=%b", k, seg_of(k), model(99, dig_of(k), al_of(k), 0));
      end
    end
    $display("xfer error v=99 seg=%b", seg_a);
    error = 1'b1;
    tick();
    error = 1'b0;
    tick();
    total++;
    if (seg_a !== model(99, 3, 1'b0, 0)) begin
      bad++;
      $display("FAIL err_idle_release got=%b exp=%b", seg_a, model(99, 3, 1'b0, 0));
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int readies = 0;
    int v = int'($urandom_range(0, 255));
    in_val   = 8'(v);
    in_valid = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (done_a === 1'b1) dones++;
      if (rdy_a === 1'b1) readies++;
    end
    in_valid = 1'b0;
    total++;
    if (dones != 3) begin bad++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    total++;
    if (readies != 3) begin bad++; $display("FAIL b2b_ready_cycles got=%0d exp=3", readies); end
    total++;
    if (seg_a !== model(v, 3, 1'b0, 0)) begin
      bad++;
      $display("FAIL b2b_seg got=%b exp=%b", seg_a, model(v, 3, 1'b0, 0));
    end
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_drain busy got=%b exp=0", busy_a); end
    $display("xfer back-to-back v=%0d dones=%0d", v, dones);
  endtask

  initial begin
    test_reset();
    test_reset_mid_convert();
    test_convert();
    test_error();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
